// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the release of an asynchronous reset, stretches it,
// then releases NUM_OUTS domain resets one after another, bit 0 first.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUTS       = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 4
) (
    input  logic                clk,
    input  logic                async_reset_n,
    input  logic                sw_reset_req,
    output logic [NUM_OUTS-1:0] sync_reset_n,
    output logic                reset_done
);

    localparam int MAX_CYCLES = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    generate
        if (SYNC_STAGES < 2) begin : g_badSyncStages
            $error("reset_sequencer: SYNC_STAGES must be at least 2");
        end
        if (NUM_OUTS < 1) begin : g_badNumOuts
            $error("reset_sequencer: NUM_OUTS must be at least 1");
        end
        if (STRETCH_CYCLES < 1) begin : g_badStretch
            $error("reset_sequencer: STRETCH_CYCLES must be at least 1");
        end
        if (STEP_CYCLES < 1) begin : g_badStep
            $error("reset_sequencer: STEP_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_syncChain;
    state_t                 r_state;
    state_t                 w_nextState;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_nextCount;
    logic [NUM_OUTS-1:0]    r_resetN;
    logic [NUM_OUTS-1:0]    w_nextResetN;
    logic [NUM_OUTS-1:0]    w_shiftMask;
    logic                   r_done;
    logic                   w_nextDone;
    logic                   w_chainOut;
    logic                   w_countEn;
    logic                   w_stretchEnd;
    logic                   w_stepEnd;
    logic                   w_lastRelease;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_syncChain <= '0;
        end else begin
            r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_chainOut   = r_syncChain[SYNC_STAGES-1];
    assign w_countEn    = w_chainOut & ~sw_reset_req;
    assign w_stretchEnd = (r_count == CNT_W'(STRETCH_CYCLES - 1));
    assign w_stepEnd    = (r_count == CNT_W'(STEP_CYCLES - 1));
    // Releasing always fills from bit 0 upward, so ordering holds by construction.
    assign w_shiftMask   = (r_resetN << 1) | NUM_OUTS'(1);
    assign w_lastRelease = &w_shiftMask;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state  <= HOLD;
            r_count  <= '0;
            r_resetN <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_resetN <= w_nextResetN;
            r_done   <= w_nextDone;
        end
    end

    // The HOLD->STRETCH edge is itself the first counted stretch edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HOLD: begin
                if (w_chainOut) begin
                    if (w_stretchEnd) begin
                        w_nextState = w_lastRelease ? DONE : RELEASE;
                    end else begin
                        w_nextState = STRETCH;
                    end
                end
            end
            STRETCH: begin
                if (w_countEn && w_stretchEnd) begin
                    w_nextState = w_lastRelease ? DONE : RELEASE;
                end
            end
            RELEASE: begin
                if (sw_reset_req) begin
                    w_nextState = STRETCH;
                end else if (w_stepEnd && w_lastRelease) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (sw_reset_req) begin
                    w_nextState = STRETCH;
                end
            end
            default: w_nextState = HOLD;
        endcase
    end

    always_comb begin
        w_nextCount  = r_count;
        w_nextResetN = r_resetN;
        w_nextDone   = r_done;
        case (r_state)
            HOLD: begin
                if (w_chainOut) begin
                    if (w_stretchEnd) begin
                        w_nextCount  = '0;
                        w_nextResetN = w_shiftMask;
                        w_nextDone   = w_lastRelease;
                    end else begin
                        w_nextCount = r_count + CNT_W'(1);
                    end
                end
            end
            STRETCH: begin
                if (sw_reset_req) begin
                    w_nextCount  = '0;
                    w_nextResetN = '0;
                    w_nextDone   = 1'b0;
                end else if (w_countEn) begin
                    if (w_stretchEnd) begin
                        w_nextCount  = '0;
                        w_nextResetN = w_shiftMask;
                        w_nextDone   = w_lastRelease;
                    end else begin
                        w_nextCount = r_count + CNT_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (sw_reset_req) begin
                    w_nextCount  = '0;
                    w_nextResetN = '0;
                    w_nextDone   = 1'b0;
                end else if (w_stepEnd) begin
                    w_nextCount  = '0;
                    w_nextResetN = w_shiftMask;
                    w_nextDone   = w_lastRelease;
                end else begin
                    w_nextCount = r_count + CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_reset_req) begin
                    w_nextCount  = '0;
                    w_nextResetN = '0;
                    w_nextDone   = 1'b0;
                end
            end
            default: begin
                w_nextCount  = '0;
                w_nextResetN = '0;
                w_nextDone   = 1'b0;
            end
        endcase
    end

    assign sync_reset_n = r_resetN;
    assign reset_done   = r_done;

endmodule
